// File: rtl/rsu_ctrl_pkg.sv
// Shared types for the remote-system-upgrade sequencer.
// Op codes, FSM states and counter sizing helpers.
package rsu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_KICK  = 2'b01,
    OP_RECFG = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_HI,
    RD_LO,
    RD_RSP,
    KICK,
    RSP,
    RECFG,
    HALT
  } state_e;

  localparam logic [7:0] RECFG_KEY_DEF = 8'hA5;

  function automatic int cnt_w(input int max_cyc);
    return $clog2(max_cyc) + 1;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rsu_ctrl_if.sv
// Host command/response bundle of the rsu sequencer.
// The controller uses the slave side, the register block the master side.
interface rsu_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_param;
  logic        cmd_ctl_nupdt;
  logic [7:0]  cmd_key;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_param,
    output cmd_ctl_nupdt,
    output cmd_key,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_err,
    input  rsp_data
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_param,
    input  cmd_ctl_nupdt,
    input  cmd_key,
    output cmd_ready,
    output rsp_valid,
    output rsp_err,
    output rsp_data
  );
endinterface

// File: rtl/rsu_kick_timer.sv
// Free-running watchdog kick period counter.
// kick_soon warns one cycle ahead so the host port can close in time.
module rsu_kick_timer
  import rsu_ctrl_pkg::*;
#(
  parameter int KICK_CYC = 125000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  output logic kick_due,
  output logic kick_soon
);

  localparam int TW = cnt_w(KICK_CYC);

  logic [TW-1:0] cnt;

  assign kick_due  = en && (cnt == TW'(KICK_CYC - 1));
  assign kick_soon = en && (cnt == TW'(KICK_CYC - 2));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || restart || kick_due) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rsu_ctrl.sv
// Sequencer in front of the rsu IP: host commands, busy
// handshake with timeouts, autonomous watchdog kicks.
module rsu_ctrl
  import rsu_ctrl_pkg::*;
#(
  parameter int         BUSY_RISE_CYC   = 8,
  parameter int         BUSY_TO_CYC     = 1024,
  parameter int         WDT_KICK_CYC    = 125000000,
  parameter int         TIMER_PULSE_CYC = 4,
  parameter int         RECFG_HOLD_CYC  = 16,
  parameter logic [7:0] RECFG_KEY       = RECFG_KEY_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  rsu_ctrl_if.slave   host,
  input  logic        wdt_en,
  output logic        recfg_active,
  output logic        rsu_read_param,
  output logic [2:0]  rsu_param,
  output logic        rsu_ctl_nupdt,
  output logic        rsu_reconfig,
  output logic        rsu_reset_timer,
  input  logic        rsu_busy,
  input  logic [31:0] rsu_data_out
);

  localparam int CMAX = imax(imax(BUSY_RISE_CYC, BUSY_TO_CYC),
                             imax(TIMER_PULSE_CYC, RECFG_HOLD_CYC));
  localparam int CW   = cnt_w(CMAX);

  state_e        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          kick_pend, kick_pend_n;
  logic          host_kick, host_kick_n;
  logic          go_recfg, go_recfg_n;
  logic          ready_n;
  logic          rsp_valid_n, rsp_err_n;
  logic [31:0]   rsp_data_n;
  logic          read_param_n, reconfig_n, reset_timer_n;
  logic [2:0]    param_n;
  logic          ctl_n;
  logic          active_n;
  logic          enter_kick;
  logic          accept;
  logic          kick_due, kick_soon;

  rsu_kick_timer #(
    .KICK_CYC (WDT_KICK_CYC)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (wdt_en && !recfg_active),
    .restart   (enter_kick),
    .kick_due  (kick_due),
    .kick_soon (kick_soon)
  );

  assign accept = host.cmd_valid && host.cmd_ready;

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    host_kick_n   = host_kick;
    go_recfg_n    = go_recfg;
    rsp_valid_n   = 1'b0;
    rsp_err_n     = 1'b0;
    rsp_data_n    = '0;
    read_param_n  = 1'b0;
    reconfig_n    = 1'b0;
    reset_timer_n = 1'b0;
    param_n       = rsu_param;
    ctl_n         = rsu_ctl_nupdt;
    active_n      = recfg_active;
    enter_kick    = 1'b0;

    unique case (state)
      IDLE: begin
        if (kick_pend || kick_due) begin
          enter_kick    = 1'b1;
          host_kick_n   = 1'b0;
          state_n       = KICK;
          cnt_n         = '0;
          reset_timer_n = 1'b1;
        end else if (accept) begin
          unique case (host.cmd_op)
            OP_READ: begin
              state_n      = RD_REQ;
              read_param_n = 1'b1;
              param_n      = host.cmd_param;
              ctl_n        = host.cmd_ctl_nupdt;
            end
            OP_KICK: begin
              enter_kick    = 1'b1;
              host_kick_n   = 1'b1;
              state_n       = KICK;
              cnt_n         = '0;
              reset_timer_n = 1'b1;
            end
            OP_RECFG: begin
              state_n     = RSP;
              rsp_valid_n = 1'b1;
              if (host.cmd_key == RECFG_KEY) begin
                go_recfg_n = 1'b1;
              end else begin
                rsp_err_n = 1'b1;
              end
            end
            default: begin
              state_n     = RSP;
              rsp_valid_n = 1'b1;
              rsp_err_n   = 1'b1;
            end
          endcase
        end
      end
      RD_REQ: begin
        state_n = RD_HI;
        cnt_n   = '0;
      end
      RD_HI: begin
        if (rsu_busy) begin
          state_n = RD_LO;
          cnt_n   = '0;
        end else if (cnt == CW'(BUSY_RISE_CYC - 1)) begin
          state_n     = RSP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RD_LO: begin
        if (!rsu_busy) begin
          state_n     = RD_RSP;
          rsp_valid_n = 1'b1;
          rsp_data_n  = rsu_data_out;
        end else if (cnt == CW'(BUSY_TO_CYC - 1)) begin
          state_n     = RSP;
          rsp_valid_n = 1'b1;
          rsp_err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RD_RSP: begin
        state_n = IDLE;
      end
      KICK: begin
        if (cnt == CW'(TIMER_PULSE_CYC - 1)) begin
          state_n     = host_kick ? RSP : IDLE;
          rsp_valid_n = host_kick;
          host_kick_n = 1'b0;
        end else begin
          cnt_n         = cnt + 1'b1;
          reset_timer_n = 1'b1;
        end
      end
      RSP: begin
        if (go_recfg) begin
          state_n    = RECFG;
          go_recfg_n = 1'b0;
          cnt_n      = '0;
          reconfig_n = 1'b1;
          active_n   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RECFG: begin
        if (cnt == CW'(RECFG_HOLD_CYC - 1)) begin
          state_n = HALT;
        end else begin
          cnt_n      = cnt + 1'b1;
          reconfig_n = 1'b1;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // an expiry landing while a kick is still pending merges into it
    kick_pend_n = enter_kick ? 1'b0 : (kick_pend || kick_due);
    ready_n     = (state_n == IDLE) && !kick_pend_n && !kick_soon;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      cnt             <= '0;
      kick_pend       <= 1'b0;
      host_kick       <= 1'b0;
      go_recfg        <= 1'b0;
      host.cmd_ready  <= 1'b0;
      host.rsp_valid  <= 1'b0;
      host.rsp_err    <= 1'b0;
      host.rsp_data   <= '0;
      rsu_read_param  <= 1'b0;
      rsu_param       <= '0;
      rsu_ctl_nupdt   <= 1'b0;
      rsu_reconfig    <= 1'b0;
      rsu_reset_timer <= 1'b0;
      recfg_active    <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      kick_pend       <= kick_pend_n;
      host_kick       <= host_kick_n;
      go_recfg        <= go_recfg_n;
      host.cmd_ready  <= ready_n;
      host.rsp_valid  <= rsp_valid_n;
      host.rsp_err    <= rsp_err_n;
      host.rsp_data   <= rsp_data_n;
      rsu_read_param  <= read_param_n;
      rsu_param       <= param_n;
      rsu_ctl_nupdt   <= ctl_n;
      rsu_reconfig    <= reconfig_n;
      rsu_reset_timer <= reset_timer_n;
      recfg_active    <= active_n;
    end
  end

endmodule

// File: tb/tb_rsu_ctrl.sv
// Bench for rsu_ctrl: timeline model of expected strobes and
// responses per cycle, checked every cycle, plus literal pins.
module tb_rsu_ctrl;
  import rsu_ctrl_pkg::*;

  localparam int B = 8;
  localparam int TO = 32;
  localparam int W = 20;
  localparam int P = 4;
  localparam int H = 16;
  localparam int N = 2048;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wdt_en = 1'b0;
  logic        recfg_active;
  logic        rp, rc, rt, ctl;
  logic [2:0]  param;
  logic        busy;
  logic [31:0] dout = '0;

  rsu_ctrl_if host();

  rsu_ctrl #(
    .BUSY_RISE_CYC   (B),
    .BUSY_TO_CYC     (TO),
    .WDT_KICK_CYC    (W),
    .TIMER_PULSE_CYC (P),
    .RECFG_HOLD_CYC  (H),
    .RECFG_KEY       (8'hA5)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .host            (host),
    .wdt_en          (wdt_en),
    .recfg_active    (recfg_active),
    .rsu_read_param  (rp),
    .rsu_param       (param),
    .rsu_ctl_nupdt   (ctl),
    .rsu_reconfig    (rc),
    .rsu_reset_timer (rt),
    .rsu_busy        (busy),
    .rsu_data_out    (dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  bit        e_rv[N];
  bit        e_re[N];
  bit [31:0] e_rd[N];
  bit        e_rp[N];
  bit        e_rt[N];
  bit        e_rc[N];
  bit        busy_tl[N];
  bit        stale = 1'b0;
  int        act_from = -1;
  int        n_checks = 0;
  int        n_pass = 0;

  assign busy = busy_tl[cyc] | stale;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, a, e);
  endtask

  always @(negedge clock) begin
    if (cyc < N) begin
      chk("rsp_valid", host.rsp_valid, e_rv[cyc]);
      if (e_rv[cyc]) begin
        chk("rsp_err", host.rsp_err, e_re[cyc]);
        chk("rsp_data", host.rsp_data, e_rd[cyc]);
      end
      chk("read_param", rp, e_rp[cyc]);
      chk("reset_timer", rt, e_rt[cyc]);
      chk("reconfig", rc, e_rc[cyc]);
      chk("recfg_active", recfg_active,
          (act_from >= 0 && cyc >= act_from));
      chk("onehot", $countones({rp, rt, rc}) <= 1, 1);
    end
  end

  task automatic idle_to(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic exp_rsp(input int c, input bit err,
                         input logic [31:0] d);
    e_rv[c] = 1'b1;
    e_re[c] = err;
    e_rd[c] = d;
  endtask

  // called at a negedge; returns the edge index that accepts
  task automatic send(input logic [1:0] op, input logic [2:0] prm,
                      input logic c, input logic [7:0] key,
                      output int k0);
    int n;
    host.cmd_op = op;
    host.cmd_param = prm;
    host.cmd_ctl_nupdt = c;
    host.cmd_key = key;
    host.cmd_valid = 1'b1;
    n = 0;
    while (!host.cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("accept_wait", n < 100, 1);
    k0 = cyc + 1;
  endtask

  task automatic drop();
    @(negedge clock);
    host.cmd_valid = 1'b0;
  endtask

  // busy high for len cycles starting r cycles after the strobe cycle
  task automatic rd(input logic [2:0] prm, input logic c,
                    input int r, input int len,
                    input logic [31:0] d, input bit keep,
                    output int k0, output int kr);
    bit err;
    dout = d;
    send(OP_READ, prm, c, 8'h00, k0);
    if (keep) begin
      busy_tl[k0-1] = 1'b1;
      busy_tl[k0] = 1'b1;
      stale = 1'b0;
    end
    e_rp[k0] = 1'b1;
    for (int i = k0 + 1 + r; i <= k0 + r + len; i++) busy_tl[i] = 1'b1;
    err = 1'b1;
    if (r + 1 > B) kr = k0 + B + 1;
    else if (len > TO) kr = k0 + r + 2 + TO;
    else begin
      kr = k0 + r + len + 2;
      err = 1'b0;
    end
    exp_rsp(kr, err, err ? 32'h0 : d);
    drop();
    chk("param_start", param, prm);
    chk("ctl_start", ctl, c);
    idle_to(kr);
    chk("param_end", param, prm);
    chk("ctl_end", ctl, c);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int k0, kr, c0, e;
    host.cmd_valid = 1'b0;
    host.cmd_op = 2'b00;
    host.cmd_param = 3'b000;
    host.cmd_ctl_nupdt = 1'b0;
    host.cmd_key = 8'h00;

    repeat (3) @(negedge clock);
    chk("rst_ready", host.cmd_ready, 0);
    chk("rst_param", param, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", host.cmd_ready, 1);

    rd(3'b010, 1'b1, 2, 5, 32'h0000_1234, 1'b0, k0, kr);
    chk("rd1_lat", kr - k0, 9);
    chk("rd1_data", host.rsp_data, 32'h1234);
    idle_to(kr + 1);

    rd(3'b001, 1'b0, B, 0, 32'h5555_AAAA, 1'b0, k0, kr);
    chk("rise_to_lat", kr - k0, B + 1);
    chk("rise_to_err", host.rsp_err, 1);
    idle_to(kr + 1);

    rd(3'b111, 1'b0, 0, 1, 32'hDEAD_BEEF, 1'b0, k0, kr);
    chk("rd2_data", host.rsp_data, 32'hDEAD_BEEF);
    idle_to(kr + 1);

    rd(3'b100, 1'b1, 1, TO + 6, 32'h0BAD_0BAD, 1'b0, k0, kr);
    chk("lo_to_lat", kr - k0, TO + 3);
    chk("lo_to_data", host.rsp_data, 0);
    idle_to(k0 + TO + 10);

    stale = 1'b1;
    repeat (2) @(negedge clock);
    rd(3'b011, 1'b0, 0, 3, 32'hCAFE_F00D, 1'b1, k0, kr);
    chk("stale_lat", kr - k0, 5);
    idle_to(kr + 1);

    send(2'b11, 3'b000, 1'b0, 8'h00, k0);
    exp_rsp(k0, 1'b1, 32'h0);
    drop();
    chk("rsvd_err", host.rsp_err, 1);
    idle_to(k0 + 1);

    send(OP_KICK, 3'b000, 1'b0, 8'h00, k0);
    for (int i = 0; i < P; i++) e_rt[k0+i] = 1'b1;
    exp_rsp(k0 + P, 1'b0, 32'h0);
    drop();
    idle_to(k0 + P + 1);

    c0 = cyc;
    wdt_en = 1'b1;
    for (int m = 1; m <= 3; m++)
      for (int i = 0; i < P; i++) e_rt[c0 + m*W + i] = 1'b1;
    e = c0 + 3*W;
    idle_to(e - 1);
    chk("ready_pre_kick", host.cmd_ready, 0);
    rd(3'b110, 1'b1, 0, 2, 32'h0000_00C3, 1'b0, k0, kr);
    chk("kick_first", k0 - e, P + 1);
    idle_to(kr + 1);
    wdt_en = 1'b0;
    idle_to(cyc + 25);

    send(OP_RECFG, 3'b000, 1'b0, 8'h00, k0);
    exp_rsp(k0, 1'b1, 32'h0);
    drop();
    chk("badkey_err", host.rsp_err, 1);
    idle_to(k0 + 3);

    dout = 32'h7777_7777;
    send(OP_READ, 3'b101, 1'b1, 8'h00, k0);
    e_rp[k0] = 1'b1;
    for (int i = k0 + 1; i < k0 + 100; i++) busy_tl[i] = 1'b1;
    drop();
    idle_to(k0 + 4);
    for (int i = k0 + 5; i < N; i++) begin
      e_rv[i] = 1'b0;
      e_rp[i] = 1'b0;
      busy_tl[i] = 1'b0;
    end
    idle_to(k0 + 5);
    reset_n = 1'b0;
    #1;
    chk("arst_param", param, 0);
    chk("arst_ctl", ctl, 0);
    chk("arst_ready", host.cmd_ready, 0);
    chk("arst_rsp", host.rsp_valid, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_rerst", host.cmd_ready, 1);
    idle_to(cyc + 3);

    send(OP_RECFG, 3'b000, 1'b0, 8'hA5, k0);
    exp_rsp(k0, 1'b0, 32'h0);
    for (int i = 1; i <= H; i++) e_rc[k0+i] = 1'b1;
    act_from = k0 + 1;
    drop();
    chk("goodkey_err", host.rsp_err, 0);
    wdt_en = 1'b1;
    host.cmd_op = OP_KICK;
    host.cmd_valid = 1'b1;
    idle_to(k0 + H + 1);
    chk("halt_reconfig", rc, 0);
    chk("halt_active", recfg_active, 1);
    while (cyc < k0 + 60) begin
      chk("halt_ready", host.cmd_ready, 0);
      @(negedge clock);
    end
    host.cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
